// File: rtl/visaccum_sat.sv
// Visibility accumulator: sums PSUMS interleaved complex partial sums over N blocks
// per frame through a read/add/write pipeline and emits one burst per completed frame.
module visaccum_sat #(
    parameter int unsigned IBITS    = 4,
    parameter int unsigned OBITS    = 12,
    parameter int unsigned PSUMS    = 3,
    parameter int unsigned CBITS    = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame_i,
    input  logic             valid_i,
    input  logic [IBITS-1:0] rdata_i,
    input  logic [IBITS-1:0] idata_i,
    input  logic [CBITS-1:0] count_i,
    output logic             frame_o,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic             sat_o,
    output logic [OBITS-1:0] rdata_o,
    output logic [OBITS-1:0] idata_o
);

    localparam int unsigned ABITS = (PSUMS > 1) ? $clog2(PSUMS) : 1;
    localparam int unsigned DEPTH = 1 << ABITS;
    localparam int unsigned EBITS = 2 * OBITS + 1;
    localparam logic [ABITS-1:0] ALAST = ABITS'(PSUMS - 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t           state;
    logic             frame_q;
    logic [ABITS-1:0] addr;
    logic [CBITS-1:0] blk;
    logic [CBITS-1:0] blk_last;

    // RAM entry layout: {sat, real, imag}
    logic [EBITS-1:0] ram [DEPTH];

    logic             rd_v, rd_out, rd_blk0;
    logic [ABITS-1:0] rd_addr;
    logic [IBITS-1:0] rd_re, rd_im;

    logic             ad_v, ad_out;
    logic [ABITS-1:0] ad_addr;
    logic [EBITS-1:0] ad_old;
    logic [IBITS-1:0] ad_re, ad_im;

    logic             frame_rise_c, abort_c, accept_c, out_c;
    logic             blk_last_c, addr_last_c;
    logic [EBITS-1:0] old_c, sum_e_c;
    logic [OBITS:0]   sum_r_c, sum_i_c;

    // Returns {overflow, result}; result clamps or wraps depending on SATURATE.
    function automatic logic [OBITS:0] add_sat(input logic [OBITS-1:0] acc,
                                               input logic [IBITS-1:0] x);
        logic [OBITS:0]   s;
        logic             ovf;
        logic [OBITS-1:0] v;
        s   = {acc[OBITS-1], acc} + {{(OBITS + 1 - IBITS){x[IBITS-1]}}, x};
        ovf = s[OBITS] ^ s[OBITS-1];
        v   = s[OBITS-1:0];
        if (ovf && (SATURATE != 0)) begin
            v = s[OBITS] ? {1'b1, {(OBITS - 1){1'b0}}} : {1'b0, {(OBITS - 1){1'b1}}};
        end
        return {ovf, v};
    endfunction

    always_comb begin
        frame_rise_c = frame_i & ~frame_q;
        abort_c      = (state == ACC) & ~frame_i;
        accept_c     = (state == ACC) & frame_i & valid_i;
        blk_last_c   = (blk == blk_last);
        addr_last_c  = (addr == ALAST);
        out_c        = ad_v & ad_out & ~abort_c;
    end

    // Frame control: block/address counters and frame start/abort/completion
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            frame_q  <= 1'b0;
            addr     <= '0;
            blk      <= '0;
            blk_last <= '0;
        end else begin
            frame_q <= frame_i;
            case (state)
                IDLE: begin
                    if (frame_rise_c) begin
                        state    <= ACC;
                        addr     <= '0;
                        blk      <= '0;
                        blk_last <= (count_i == '0) ? '0 : count_i - CBITS'(1);
                    end
                end
                ACC: begin
                    if (!frame_i) begin
                        state <= IDLE;
                    end else if (valid_i) begin
                        if (addr_last_c) begin
                            addr <= '0;
                            if (blk_last_c) begin
                                state <= IDLE;
                            end else begin
                                blk <= blk + CBITS'(1);
                            end
                        end else begin
                            addr <= addr + ABITS'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read stage operand: block 0 starts from zero; the add stage's pending result wins over RAM
    always_comb begin
        old_c = ram[rd_addr];
        if (ad_v && (ad_addr == rd_addr)) begin
            old_c = sum_e_c;
        end
        if (rd_blk0) begin
            old_c = '0;
        end
    end

    always_comb begin
        sum_r_c = add_sat(ad_old[2*OBITS-1:OBITS], ad_re);
        sum_i_c = add_sat(ad_old[OBITS-1:0], ad_im);
        sum_e_c = {ad_old[2*OBITS] | sum_r_c[OBITS] | sum_i_c[OBITS],
                   sum_r_c[OBITS-1:0], sum_i_c[OBITS-1:0]};
    end

    always_ff @(posedge clock) begin
        if (ad_v) begin
            ram[ad_addr] <= sum_e_c;
        end
    end

    always_ff @(posedge clock) begin
        rd_addr <= addr;
        rd_blk0 <= (blk == '0);
        rd_re   <= rdata_i;
        rd_im   <= idata_i;
        ad_addr <= rd_addr;
        ad_old  <= old_c;
        ad_re   <= rd_re;
        ad_im   <= rd_im;
    end

    // Pipeline valids and registered outputs; an abort squashes in-flight output beats
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_v    <= 1'b0;
            rd_out  <= 1'b0;
            ad_v    <= 1'b0;
            ad_out  <= 1'b0;
            frame_o <= 1'b0;
            valid_o <= 1'b0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
            sat_o   <= 1'b0;
            rdata_o <= '0;
            idata_o <= '0;
        end else begin
            rd_v    <= accept_c;
            rd_out  <= accept_c & blk_last_c;
            ad_v    <= rd_v;
            ad_out  <= rd_out & ~abort_c;
            valid_o <= out_c;
            first_o <= out_c & (ad_addr == '0);
            last_o  <= out_c & (ad_addr == ALAST);
            if (out_c) begin
                sat_o   <= sum_e_c[2*OBITS];
                rdata_o <= sum_e_c[2*OBITS-1:OBITS];
                idata_o <= sum_e_c[OBITS-1:0];
            end
            if (out_c && (ad_addr == '0)) begin
                frame_o <= 1'b1;
            end else if (abort_c || (valid_o && last_o)) begin
                frame_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_visaccum_sat.sv
// Bench for visaccum_sat: four parameter variants share one stimulus stream and are
// compared every cycle against a per-beat arithmetic reference model.
module tb_visaccum_sat;

    localparam int NI = 4;

    logic       clock = 1'b0;
    logic       reset, frame_i, valid_i;
    logic [3:0] rdata_i, idata_i;
    logic [7:0] count_i;

    logic fo[NI], vo[NI], fi[NI], la[NI], so[NI];
    logic [11:0] r0, i0, r1, i1;
    logic [5:0]  r2, i2, r3, i3;
    logic signed [31:0] orr[NI], oii[NI];

    assign orr[0] = 32'($signed(r0));
    assign oii[0] = 32'($signed(i0));
    assign orr[1] = 32'($signed(r1));
    assign oii[1] = 32'($signed(i1));
    assign orr[2] = 32'($signed(r2));
    assign oii[2] = 32'($signed(i2));
    assign orr[3] = 32'($signed(r3));
    assign oii[3] = 32'($signed(i3));

    always #5 clock = ~clock;

    visaccum_sat u0 (.clock(clock), .reset(reset), .frame_i(frame_i), .valid_i(valid_i),
        .rdata_i(rdata_i), .idata_i(idata_i), .count_i(count_i), .frame_o(fo[0]),
        .valid_o(vo[0]), .first_o(fi[0]), .last_o(la[0]), .sat_o(so[0]),
        .rdata_o(r0), .idata_o(i0));
    visaccum_sat #(.PSUMS(1)) u1 (.clock(clock), .reset(reset), .frame_i(frame_i),
        .valid_i(valid_i), .rdata_i(rdata_i), .idata_i(idata_i), .count_i(count_i),
        .frame_o(fo[1]), .valid_o(vo[1]), .first_o(fi[1]), .last_o(la[1]), .sat_o(so[1]),
        .rdata_o(r1), .idata_o(i1));
    visaccum_sat #(.OBITS(6), .SATURATE(1)) u2 (.clock(clock), .reset(reset),
        .frame_i(frame_i), .valid_i(valid_i), .rdata_i(rdata_i), .idata_i(idata_i),
        .count_i(count_i), .frame_o(fo[2]), .valid_o(vo[2]), .first_o(fi[2]),
        .last_o(la[2]), .sat_o(so[2]), .rdata_o(r2), .idata_o(i2));
    visaccum_sat #(.OBITS(6), .SATURATE(0)) u3 (.clock(clock), .reset(reset),
        .frame_i(frame_i), .valid_i(valid_i), .rdata_i(rdata_i), .idata_i(idata_i),
        .count_i(count_i), .frame_o(fo[3]), .valid_o(vo[3]), .first_o(fi[3]),
        .last_o(la[3]), .sat_o(so[3]), .rdata_o(r3), .idata_o(i3));

    function automatic int ps_of(int n);  return (n == 1) ? 1 : 3;  endfunction
    function automatic int ob_of(int n);  return (n >= 2) ? 6 : 12; endfunction
    function automatic bit sat_of(int n); return n != 3;            endfunction

    // Reference model state per instance
    bit act[NI];
    int nblk[NI], ad[NI], bk[NI];
    int accr[NI][3], acci[NI][3];
    bit accs[NI][3];
    // Expected output beats keyed by due edge modulo 4
    bit sv[NI][4], sf[NI][4], sl[NI][4], ss[NI][4];
    int sr[NI][4], si[NI][4];
    int er[NI], ei[NI];
    bit es[NI], efr[NI], plast[NI];
    bit fprev;
    int cyc, vecs, errs;

    function automatic int fit(input int s, input int ob, input bit sat, output bit ovf);
        int mx, mn, m;
        mx  = (1 << (ob - 1)) - 1;
        mn  = -(1 << (ob - 1));
        m   = 1 << ob;
        ovf = (s > mx) || (s < mn);
        if (!ovf) return s;
        if (sat) return (s > mx) ? mx : mn;
        return (((s - mn) % m) + m) % m + mn;
    endfunction

    task automatic chk(input string tag, input int n, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s u%0d cyc=%0d observed=%0d expected=%0d", tag, n, cyc, obs, exp);
        end
    endtask

    // Apply the model for the upcoming clock edge using the inputs currently driven
    task automatic model_edge();
        int  k, xr, xi, s;
        bit  o1, o2, rise;
        k    = cyc + 1;
        rise = frame_i && !fprev;
        xr   = int'($signed(rdata_i));
        xi   = int'($signed(idata_i));
        for (int n = 0; n < NI; n++) begin
            if (reset) begin
                act[n] = 0;
                for (int j = 0; j < 4; j++) sv[n][j] = 0;
                er[n] = 0; ei[n] = 0; es[n] = 0; efr[n] = 0; plast[n] = 0;
            end else if (!act[n]) begin
                if (rise) begin
                    act[n]  = 1;
                    nblk[n] = (count_i == 0) ? 1 : int'(count_i);
                    ad[n]   = 0;
                    bk[n]   = 0;
                end
            end else if (!frame_i) begin
                act[n] = 0;
                efr[n] = 0;
                sv[n][k % 4] = 0;
                sv[n][(k + 1) % 4] = 0;
            end else if (valid_i) begin
                if (bk[n] == 0) begin
                    accr[n][ad[n]] = xr;
                    acci[n][ad[n]] = xi;
                    accs[n][ad[n]] = 0;
                end else begin
                    accr[n][ad[n]] = fit(accr[n][ad[n]] + xr, ob_of(n), sat_of(n), o1);
                    acci[n][ad[n]] = fit(acci[n][ad[n]] + xi, ob_of(n), sat_of(n), o2);
                    accs[n][ad[n]] = accs[n][ad[n]] | o1 | o2;
                end
                if (bk[n] == nblk[n] - 1) begin
                    s = (k + 2) % 4;
                    sv[n][s] = 1;
                    sf[n][s] = (ad[n] == 0);
                    sl[n][s] = (ad[n] == ps_of(n) - 1);
                    ss[n][s] = accs[n][ad[n]];
                    sr[n][s] = accr[n][ad[n]];
                    si[n][s] = acci[n][ad[n]];
                end
                ad[n]++;
                if (ad[n] == ps_of(n)) begin
                    ad[n] = 0;
                    bk[n]++;
                    if (bk[n] == nblk[n]) act[n] = 0;
                end
            end
        end
        fprev = reset ? 1'b0 : frame_i;
    endtask

    task automatic check_all();
        int s;
        bit v;
        s = cyc % 4;
        for (int n = 0; n < NI; n++) begin
            v = sv[n][s];
            if (v) begin
                er[n] = sr[n][s];
                ei[n] = si[n][s];
                es[n] = ss[n][s];
                efr[n] = sf[n][s] ? 1'b1 : (plast[n] ? 1'b0 : efr[n]);
            end else if (plast[n]) begin
                efr[n] = 0;
            end
            chk("valid_o", n, vo[n], v);
            if (v) begin
                chk("first_o", n, fi[n], sf[n][s]);
                chk("last_o", n, la[n], sl[n][s]);
            end
            chk("rdata_o", n, orr[n], er[n]);
            chk("idata_o", n, oii[n], ei[n]);
            chk("sat_o", n, so[n], es[n]);
            chk("frame_o", n, fo[n], efr[n]);
            plast[n] = v && sl[n][s];
            sv[n][s] = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        cyc++;
        #1 check_all();
    endtask

    // One frame: rise cycle with an ignored beat, nbeats beats with optional gaps, then drop frame
    task automatic run_frame(input int cnt, input int nbeats, input int rv, input int iv,
                             input bit rnd, input int gap_max);
        frame_i = 1'b1;
        count_i = 8'(cnt);
        valid_i = 1'b1;
        rdata_i = 4'($urandom);
        idata_i = 4'($urandom);
        tick();
        count_i = 8'($urandom);
        for (int b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                valid_i = 1'b0;
                rdata_i = 4'($urandom);
                tick();
            end
            valid_i = 1'b1;
            rdata_i = rnd ? 4'($urandom) : 4'(rv);
            idata_i = rnd ? 4'($urandom) : 4'(iv);
            tick();
        end
        frame_i = 1'b0;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        int n, nb;
        vecs = 0; errs = 0; cyc = 0; fprev = 0;
        for (int k = 0; k < NI; k++) begin
            act[k] = 0; er[k] = 0; ei[k] = 0; es[k] = 0; efr[k] = 0; plast[k] = 0;
            for (int j = 0; j < 4; j++) sv[k][j] = 0;
        end
        reset = 1'b1; frame_i = 1'b0; valid_i = 1'b0;
        rdata_i = '0; idata_i = '0; count_i = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        run_frame(5, 15, 1, -2, 0, 0);
        run_frame(4, 12, 3, 1, 0, 0);
        run_frame(10, 30, 7, -8, 0, 0);
        run_frame(2, 6, 2, 0, 0, 1);
        run_frame(2, 6, -1, 0, 0, 0);
        run_frame(3, 4, 4, 4, 0, 0);
        run_frame(1, 3, 5, 5, 0, 0);
        run_frame(0, 3, -8, -8, 0, 0);

        for (int t = 0; t < 10; t++) begin
            if (t % 4 == 3) begin
                n  = int'($urandom_range(5, 2));
                nb = int'($urandom_range((n - 1) * 3, 1));
            end else begin
                n  = int'($urandom_range(5, 0));
                nb = (n == 0) ? 3 : n * 3;
            end
            run_frame(n, nb, 0, 0, 1, t % 3);
        end

        run_frame(1, 3, 6, -3, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        run_frame(2, 6, 0, 0, 1, 1);
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
